// File: rtl/systolic_skew_buf_if.sv
// Operand stream bundle between the loader (master) and the skew buffer (slave).
// Carries the input vector handshake and the skewed per-lane outputs.
interface systolic_skew_buf_if #(
   parameter int BITS = 8,
   parameter int DIM  = 8
);
   logic                   in_valid;
   logic                   in_last;
   logic signed [BITS-1:0] in_data [DIM];
   logic                   in_ready;
   logic signed [BITS-1:0] out_data [DIM];
   logic [DIM-1:0]         out_valid;
   logic                   busy;
   logic                   done;

   modport master (
      output in_valid, in_last, in_data,
      input  in_ready, out_data, out_valid, busy, done
   );

   modport slave (
      input  in_valid, in_last, in_data,
      output in_ready, out_data, out_valid, busy, done
   );
endinterface

// File: rtl/systolic_skew_buf.sv
// Input-skewing buffer: lane i delays its element by a staircase depth so operands reach the array diagonally.
// Optional SKEW_BUF_CLR_EN adds a synchronous clr port that flushes stages, counter, FSM and done.
module systolic_skew_buf #(
   parameter int BITS   = 8,
   parameter int DIM    = 8,
   parameter bit ASCEND = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
`ifdef SKEW_BUF_CLR_EN
   input  logic clr,
`endif
   systolic_skew_buf_if.slave bus
);

   localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          done_q, done_n;
   logic          clr_i;
   logic          accept;

`ifdef SKEW_BUF_CLR_EN
   assign clr_i = clr;
`else
   assign clr_i = 1'b0;
`endif

   assign bus.in_ready = en & (state != DRAIN);
   assign accept       = bus.in_valid & bus.in_ready;
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done_n  = 1'b0;
      case (state)
         IDLE, STREAM: begin
            if (accept) begin
               if (bus.in_last) begin
                  state_n = DRAIN;
                  cnt_n   = CW'(DIM - 1);
               end else begin
                  state_n = STREAM;
               end
            end
         end
         DRAIN: begin
            // done is registered on the edge that moves the last element into the deepest stage
            if (cnt <= CW'(1)) begin
               done_n  = 1'b1;
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         state  <= IDLE;
         cnt    <= '0;
         done_q <= 1'b0;
      end else if (en) begin
         state  <= state_n;
         cnt    <= cnt_n;
         done_q <= done_n;
      end else begin
         done_q <= 1'b0;
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      localparam int D = ASCEND ? i + 1 : DIM - i;

      logic signed [BITS-1:0] sd [D];
      logic                   sv [D];

      // NOTE: the stage arrays are cleared on reset because a stale valid bit would reach the array edge.
      always_ff @(posedge clk) begin
         if (!rst_n || clr_i) begin
            for (int s = 0; s < D; s++) begin
               sd[s] <= '0;
               sv[s] <= 1'b0;
            end
         end else if (en) begin
            sv[0] <= accept;
            sd[0] <= accept ? bus.in_data[i] : '0;
            for (int s = 1; s < D; s++) begin
               sv[s] <= sv[s-1];
               sd[s] <= sd[s-1];
            end
         end
      end

      // Bubbles carry zero data, so the last stage is already zero-filled.
      assign bus.out_data[i]  = sd[D-1];
      assign bus.out_valid[i] = sv[D-1];
   end

endmodule

// File: tb/tb_systolic_skew_buf.sv
// Scoreboard bench: ascending and descending DIM=4 buffers share one stimulus stream;
// the model predicts, per accepted vector, the advancing-cycle index at which each lane shows it.
module tb_systolic_skew_buf;

   localparam int BITS = 8;
   localparam int DIM  = 4;
   localparam int NI   = 2;   // instance 0 ascending, instance 1 descending

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
`ifdef SKEW_BUF_CLR_EN
   logic clr = 1'b0;
`endif
   logic                   in_valid = 1'b0;
   logic                   in_last  = 1'b0;
   logic signed [BITS-1:0] in_data [DIM];

   always #5 clk = ~clk;

   systolic_skew_buf_if #(.BITS(BITS), .DIM(DIM)) bus_a ();
   systolic_skew_buf_if #(.BITS(BITS), .DIM(DIM)) bus_d ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_last  = in_last;
   assign bus_a.in_data  = in_data;
   assign bus_d.in_valid = in_valid;
   assign bus_d.in_last  = in_last;
   assign bus_d.in_data  = in_data;

   systolic_skew_buf #(.BITS(BITS), .DIM(DIM), .ASCEND(1'b1)) u_asc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
`ifdef SKEW_BUF_CLR_EN
      .clr   (clr),
`endif
      .bus   (bus_a)
   );

   systolic_skew_buf #(.BITS(BITS), .DIM(DIM), .ASCEND(1'b0)) u_desc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
`ifdef SKEW_BUF_CLR_EN
      .clr   (clr),
`endif
      .bus   (bus_d)
   );

   logic [DIM-1:0]         ov  [NI];
   logic signed [BITS-1:0] od  [NI][DIM];
   logic                   dn  [NI];
   logic                   rdy [NI];
   logic                   bsy [NI];

   always_comb begin
      for (int i = 0; i < DIM; i++) begin
         od[0][i] = bus_a.out_data[i];
         od[1][i] = bus_d.out_data[i];
      end
      ov[0]  = bus_a.out_valid;  ov[1]  = bus_d.out_valid;
      dn[0]  = bus_a.done;       dn[1]  = bus_d.done;
      rdy[0] = bus_a.in_ready;   rdy[1] = bus_d.in_ready;
      bsy[0] = bus_a.busy;       bsy[1] = bus_d.busy;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic signed [BITS-1:0] data;
      int                     due;
   } exp_t;

   exp_t lane_q [NI][DIM][$];
   int   done_q [NI][$];
   int   adv_cnt     = 0;   // advancing edges since reset
   int   drain_until = 0;   // advancing edge at which done fires; not ready before it
   bit   block_open  = 1'b0;
   bit   last_adv    = 1'b0;
   bit   last_clear  = 1'b0;
   bit   mon_on      = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [DIM-1:0]         snap_v [NI];
   logic signed [BITS-1:0] snap_d [NI][DIM];

   function automatic int depth(input int k, input int i);
      return (k == 0) ? i + 1 : DIM - i;
   endfunction

   function automatic int drain_gap();
      return (DIM > 1) ? DIM - 1 : 1;
   endfunction

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_clear();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < DIM; i++) lane_q[k][i].delete();
         done_q[k].delete();
      end
      adv_cnt     = 0;
      drain_until = 0;
      block_open  = 1'b0;
   endtask

   // One clock edge with the given controls; the model is updated at the edge.
   task automatic step(input bit e, input bit v, input bit l);
      bit acc;
      en = e; in_valid = v; in_last = l;
      @(posedge clk);
      last_clear = 1'b0;
      last_adv   = e;
      if (e) begin
         acc = v && (adv_cnt >= drain_until);
         adv_cnt++;
         if (acc) begin
            for (int k = 0; k < NI; k++)
               for (int i = 0; i < DIM; i++)
                  lane_q[k][i].push_back('{data: in_data[i], due: adv_cnt + depth(k, i) - 1});
            if (l) begin
               drain_until = adv_cnt + drain_gap();
               for (int k = 0; k < NI; k++) done_q[k].push_back(drain_until);
               block_open = 1'b0;
            end else begin
               block_open = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic reset_step();
      rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_last = 1'b1;
      for (int i = 0; i < DIM; i++) in_data[i] = BITS'($urandom);
      @(posedge clk);
      model_clear();
      last_clear = 1'b1;
      last_adv   = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_vec(input int base, input int stride);
      for (int i = 0; i < DIM; i++) in_data[i] = BITS'(base + stride * i);
   endtask

   task automatic rand_vec();
      for (int i = 0; i < DIM; i++) in_data[i] = BITS'($urandom);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_on) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("in_ready[%0d]", k), 64'(rdy[k]), 64'(en && (adv_cnt >= drain_until)));
            check($sformatf("busy[%0d]", k), 64'(bsy[k]), 64'(block_open || (adv_cnt < drain_until)));
            if (last_clear) begin
               check($sformatf("clear_done[%0d]", k), 64'(dn[k]), 64'(0));
               check($sformatf("clear_valid[%0d]", k), 64'(ov[k]), 64'(0));
               for (int i = 0; i < DIM; i++)
                  check($sformatf("clear_data[%0d][%0d]", k, i), 64'(od[k][i]), 64'(0));
            end else if (last_adv) begin
               bit exp_done;
               exp_done = (done_q[k].size() > 0) && (done_q[k][0] == adv_cnt);
               if (exp_done) void'(done_q[k].pop_front());
               check($sformatf("done[%0d]@%0d", k, adv_cnt), 64'(dn[k]), 64'(exp_done));
               for (int i = 0; i < DIM; i++) begin
                  bit exp_v;
                  exp_v = (lane_q[k][i].size() > 0) && (lane_q[k][i][0].due == adv_cnt);
                  check($sformatf("valid[%0d][%0d]@%0d", k, i, adv_cnt), 64'(ov[k][i]), 64'(exp_v));
                  if (exp_v) begin
                     check($sformatf("data[%0d][%0d]@%0d", k, i, adv_cnt), 64'(od[k][i]),
                           64'(lane_q[k][i][0].data));
                     void'(lane_q[k][i].pop_front());
                  end else begin
                     check($sformatf("bubble[%0d][%0d]@%0d", k, i, adv_cnt), 64'(od[k][i]), 64'(0));
                  end
               end
            end else begin
               check($sformatf("stall_done[%0d]", k), 64'(dn[k]), 64'(0));
               check($sformatf("stall_valid[%0d]", k), 64'(ov[k]), 64'(snap_v[k]));
               for (int i = 0; i < DIM; i++)
                  check($sformatf("stall_data[%0d][%0d]", k, i), 64'(od[k][i]), 64'(snap_d[k][i]));
            end
            snap_v[k] = ov[k];
            for (int i = 0; i < DIM; i++) snap_d[k][i] = od[k][i];
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < DIM; i++) in_data[i] = '0;

      reset_step();
      mon_on = 1'b1;
      step(1, 0, 0);

      // Ascending skew example plus descending view of the same stream
      set_vec(1, 1);  step(1, 1, 0);
      set_vec(5, 1);  step(1, 1, 1);
      for (int c = 0; c < 6; c++) step(1, 0, 0);

      // Negative values through a single-vector block
      set_vec(-1, -1); step(1, 1, 1);
      for (int c = 0; c < 6; c++) step(1, 0, 0);

      // Stall for three cycles mid-stream
      set_vec(9, 2);   step(1, 1, 0);
      set_vec(20, 3);  step(1, 1, 0);
      for (int c = 0; c < 3; c++) step(0, 1, 0);
      set_vec(-50, 7); step(1, 1, 1);
      for (int c = 0; c < 2; c++) step(1, 1, 0);
      step(0, 1, 0);
      for (int c = 0; c < 6; c++) step(1, 0, 0);

      // Source holds in_valid through DRAIN; next vector goes in right after done
      set_vec(100, 1); step(1, 1, 1);
      set_vec(-100, 1);
      for (int c = 0; c < 5; c++) step(1, 1, (c == 4));
      for (int c = 0; c < 6; c++) step(1, 0, 0);

      // Reset mid-block: data discarded, no done
      set_vec(33, 1); step(1, 1, 0);
      set_vec(44, 1); step(1, 1, 1);
      reset_step();
      for (int c = 0; c < 6; c++) step(1, 0, 0);

`ifdef SKEW_BUF_CLR_EN
      set_vec(60, 1); step(1, 1, 0);
      set_vec(70, 1); step(1, 1, 0);
      en = 1'b0; clr = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      model_clear();
      last_clear = 1'b1;
      last_adv   = 1'b0;
      #1;
      clr = 1'b0;
      for (int c = 0; c < 6; c++) step(1, 0, 0);
`endif

      // Randomised traffic
      for (int c = 0; c < 800; c++) begin
         rand_vec();
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0));
      end

      for (int c = 0; c < DIM + 3; c++) step(1, 0, 0);
      @(negedge clk);
      mon_on = 1'b0;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("done_q_empty[%0d]", k), 64'(done_q[k].size()), 64'(0));
         for (int i = 0; i < DIM; i++)
            check($sformatf("lane_q_empty[%0d][%0d]", k, i), 64'(lane_q[k][i].size()), 64'(0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
